vga_fetch_sched: RTL

Scanline fetch scheduler and memory arbiter for the 800x600 VGA pipeline. It watches the video timing strobes (hs/vs/h_active/v_active) and fills a two-bank line buffer from the shared framebuffer memory one line ahead of display. The same memory port is shared with a CPU requester. Video fetch has priority, but the CPU is guaranteed one access between video bursts.

---
 rtl/vga_fetch_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/vga_fetch_sched.sv
// Scanline fetch scheduler: prefetches display lines into a two-bank line buffer and
// shares the framebuffer port with a CPU. Optional macro UNDERRUN_CNT_EN adds an underrun counter.
module vga_fetch_sched #(
    parameter int WORDS_PER_LINE = 200,
    parameter int BURST          = 8,
    parameter int LINES          = 600,
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE),
    localparam int LINE_W        = $clog2(LINES + 1),
    localparam int BC_W          = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic              clock,
    input  logic              rst_i,
    input  logic              h_active,
    input  logic              v_active,
    input  logic              vs,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [IDX_W:0]    lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun,
    output logic [15:0]       underrun_count,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_pending,
    output logic [LINE_W-1:0] dbg_disp_line
);

    // Memory handshake: mem_req and its address/write fields stay stable until mem_ack;
    // one word moves on every cycle where mem_req and mem_ack are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, VID = 2'd1, CPU = 2'd2} state_t;

    state_t              state, state_nx;
    logic [1:0]          pending;
    logic [LINE_W-1:0]   disp_line;
    logic [ADDR_W-1:0]   fetch_addr, base_q;
    logic                h_active_q, vs_q, cpu_turn, frame_pend, bank;
    logic [IDX_W-1:0]    idx;
    logic [BC_W-1:0]     burst_cnt;

    logic vs_rise, line_end, vid_ack, burst_done, line_done, restart, dec, line_req, under_nx;
    logic [2:0] pend_sum;

    assign vs_rise    = vs & ~vs_q;
    assign line_end   = ~h_active & h_active_q & v_active;
    assign vid_ack    = (state == VID) & mem_ack;
    assign burst_done = vid_ack & (burst_cnt == BC_W'(BURST - 1));
    assign line_done  = vid_ack & (idx == IDX_W'(WORDS_PER_LINE - 1));
    // A frame restart waits for an in-flight video burst so its handshake is never cut short.
    assign restart    = (vs_rise & (state != VID)) | (burst_done & (frame_pend | vs_rise));
    assign dec        = line_done & ~frame_pend & ~vs_rise;
    assign line_req   = line_end & ((32'(disp_line) + 32'd2) < 32'(LINES));
    assign under_nx   = ~vs_rise & line_req & (pending != 2'd0) & ~dec;
    assign pend_sum   = {1'b0, pending} - {2'b00, dec} + {2'b00, line_req};

    assign dbg_state     = state;
    assign dbg_pending   = pending;
    assign dbg_disp_line = disp_line;

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        case (state)
            IDLE: begin
                if ((pending != 2'd0) && !cpu_turn)
                    state_nx = VID;
                else if (cpu_req && (cpu_turn || (pending == 2'd0)))
                    state_nx = CPU;
            end
            VID: begin
                mem_req  = 1'b1;
                mem_addr = fetch_addr;
                if (burst_done)
                    state_nx = IDLE;
            end
            CPU: begin
                mem_req   = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_ack   = mem_ack;
                cpu_rdata = mem_rdata;
                if (mem_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pending    <= 2'd0;
            disp_line  <= '0;
            fetch_addr <= '0;
            base_q     <= '0;
            h_active_q <= 1'b0;
            vs_q       <= 1'b0;
            cpu_turn   <= 1'b0;
            frame_pend <= 1'b0;
            bank       <= 1'b0;
            idx        <= '0;
            burst_cnt  <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            lb_wdata   <= '0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            h_active_q <= h_active;
            vs_q       <= vs;
            underrun   <= under_nx;

            if (vs_rise)
                base_q <= fb_base;

            if (vs_rise)
                disp_line <= '0;
            else if (line_end)
                disp_line <= disp_line + LINE_W'(1);

            if (vs_rise)
                pending <= 2'd2;
            else if (pend_sum > 3'd2)
                pending <= 2'd2;
            else
                pending <= pend_sum[1:0];

            if (restart)
                frame_pend <= 1'b0;
            else if (vs_rise)
                frame_pend <= 1'b1;

            if (restart) begin
                fetch_addr <= vs_rise ? fb_base : base_q;
                idx        <= '0;
                bank       <= 1'b0;
            end else if (vid_ack) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
                if (line_done) begin
                    idx  <= '0;
                    bank <= ~bank;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            if (vid_ack)
                burst_cnt <= burst_done ? '0 : burst_cnt + BC_W'(1);

            // cpu_turn guarantees the CPU one slot between bursts; drop it if the CPU withdrew.
            if (burst_done)
                cpu_turn <= cpu_req;
            else if ((state == CPU) && mem_ack)
                cpu_turn <= 1'b0;
            else if ((state == IDLE) && !cpu_req)
                cpu_turn <= 1'b0;

            lb_we <= vid_ack;
            if (vid_ack) begin
                lb_addr  <= {bank, idx};
                lb_wdata <= mem_rdata;
            end
        end
    end

`ifdef UNDERRUN_CNT_EN
    always_ff @(posedge clock or posedge rst_i) begin
        if (rst_i)
            underrun_count <= 16'd0;
        else if (under_nx && (underrun_count != 16'hFFFF))
            underrun_count <= underrun_count + 16'd1;
    end
`else
    assign underrun_count = 16'd0;
`endif

endmodule
